memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/mem_pkg.sv | 15 +
 rtl/memory.sv | 51 +++++
 tb/tb_memory.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the word-addressed data memory: default geometry and
// the byte-address field positions used by the word decode.
package mem_pkg;

  localparam int MEM_WIDTH_DEF = 32;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int MEM_ADDR_W    = 32;
  localparam int MEM_WORD_LSB  = 2;

  // Highest address bit that belongs to the word index for a given depth.
  function automatic int mem_idx_hi(input int depth);
    return $clog2(depth) + MEM_WORD_LSB - 1;
  endfunction

endpackage

// File: rtl/memory.sv
// Data memory: DEPTH x WIDTH words, byte-addressed, synchronous write,
// combinational read, asynchronous active-low clear of the whole array.
module memory
  import mem_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH_DEF,
  parameter int DEPTH = MEM_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [MEM_ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]      WriteData,
  output logic [WIDTH-1:0]      ReadData
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int IDX_HI = mem_idx_hi(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             wr_en;
  logic             unused_byte_off;

  assign word_idx        = address[IDX_HI:MEM_WORD_LSB];
  assign in_range        = ~|address[MEM_ADDR_W-1:IDX_HI+1];
  assign unused_byte_off = ^address[MEM_WORD_LSB-1:0];

  // Compared against 1'b1 so an unknown enable resolves to "no write".
  assign wr_en = (memWrite == 1'b1) && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= WriteData;
    end
  end

  always_comb begin
    ReadData = '0;
    if ((rst_n == 1'b1) && (memRead == 1'b1) && in_range) begin
      ReadData = mem_q[word_idx];
    end
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed table, hand-written reset
// sequences and randomized traffic against an array reference model.
module tb_memory;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  logic             clk;
  logic             rst_n;
  logic             memRead;
  logic             memWrite;
  logic [31:0]      address;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] ReadData;

  int vectors;
  int miscompares;

  logic [WIDTH-1:0] model [DEPTH];

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t tbl[$];

  memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .memRead  (memRead),
    .memWrite (memWrite),
    .address  (address),
    .WriteData(WriteData),
    .ReadData (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return a < 32'(4 * DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] m_read(input bit rd, input logic [31:0] a);
    if (!rd || !m_in_range(a)) return '0;
    return model[m_idx(a)];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic model_edge(input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (wr && m_in_range(a)) model[m_idx(a)] = d;
  endtask

  // One transaction: drive at negedge, sample before and after the next posedge.
  task automatic apply(input string name, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_pre, input logic [31:0] exp_post);
    @(negedge clk);
    memRead = rd; memWrite = wr; address = a; WriteData = d;
    #1 check({name, "/pre"}, ReadData, exp_pre);
    @(posedge clk);
    model_edge(wr, a, d);
    #1 check({name, "/post"}, ReadData, exp_post);
  endtask

  task automatic idle();
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; WriteData = '0;
    model_clear();

    // Reset recovery.
    #3 rst_n = 1'b0;
    memRead = 1'b1;
    #1 check("reset_readdata", ReadData, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("reset_recovery_read0", ReadData, 32'h0);

    tbl.push_back('{"wr12_addr0",      1, 1, 32'h0,        32'd12,        32'h0,  32'd12});
    tbl.push_back('{"rd_disabled",     0, 0, 32'h0,        32'd0,         32'h0,  32'h0});
    tbl.push_back('{"no_write_hold",   1, 0, 32'h0,        32'd0,         32'd12, 32'd12});
    tbl.push_back('{"wrA5_addr4",      0, 1, 32'h4,       32'hA5,        32'h0,  32'h0});
    tbl.push_back('{"unaligned_rd7",   1, 0, 32'h7,        32'h0,         32'hA5, 32'hA5});
    tbl.push_back('{"oor_write",       1, 1, 32'(4*DEPTH), 32'hDEAD,     32'h0,  32'h0});
    tbl.push_back('{"word0_unchanged", 1, 0, 32'h0,        32'h0,         32'd12, 32'd12});
    tbl.push_back('{"wr1_addr8",       0, 1, 32'h8,        32'd1,         32'h0,  32'h0});
    tbl.push_back('{"rw_same_addr8",   1, 1, 32'h8,        32'd2,         32'd1,  32'd2});
    tbl.push_back('{"oor_high_bit",    1, 1, 32'h8000_0000, 32'd5,        32'h0,  32'h0});
    tbl.push_back('{"last_word_wr",    1, 1, 32'h3FF,      32'h55,        32'h0,  32'h55});
    tbl.push_back('{"first_oor_rd",    1, 0, 32'h400,      32'h0,         32'h0,  32'h0});
    tbl.push_back('{"last_word_rd",    1, 0, 32'h3FC,      32'hFFFF_FFFF, 32'h55, 32'h55});
    tbl.push_back('{"wdata_ignored",   1, 0, 32'h4,        32'h1234,      32'hA5, 32'hA5});

    foreach (tbl[i])
      apply(tbl[i].name, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_pre, tbl[i].exp_post);
    idle();

    // Reset pulse between edges while reading word 0.
    memRead = 1'b1; address = 32'h0;
    #1 check("pre_pulse_word0", ReadData, 32'd12);
    #1 rst_n = 1'b0;
    #1 check("pulse_readdata_now", ReadData, 32'h0);
    #1 rst_n = 1'b1;
    model_clear();
    #1 check("after_pulse_word0", ReadData, 32'h0);
    address = 32'h8;
    #1 check("after_pulse_word2", ReadData, 32'h0);

    // Write held across a reset: discarded; first write after release lands.
    @(negedge clk);
    memWrite = 1'b1; memRead = 1'b1; address = 32'h10; WriteData = 32'hCAFE;
    rst_n = 1'b0;
    @(posedge clk);
    #1 check("write_during_reset_rd", ReadData, 32'h0);
    @(negedge clk);
    memWrite = 1'b0; rst_n = 1'b1;
    #1 check("write_during_reset_lost", ReadData, 32'h0);
    apply("first_write_after_release", 1, 1, 32'h10, 32'hBEEF, 32'h0, 32'hBEEF);
    idle();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      bit          rd, wr;
      logic [31:0] a, d, exp_pre;
      rd = 1'($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom)};
      else                           a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      d = $urandom;
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        memRead = 1'b1; memWrite = 1'b0;
        rst_n = 1'b0;
        model_clear();
        #1 check("rand_reset", ReadData, 32'h0);
        #1 rst_n = 1'b1;
      end
      exp_pre = m_read(rd, a);
      @(negedge clk);
      memRead = rd; memWrite = wr; address = a; WriteData = d;
      #1 check("rand_pre", ReadData, exp_pre);
      @(posedge clk);
      model_edge(wr, a, d);
      #1 check("rand_post", ReadData, m_read(rd, a));
    end
    idle();

    // Sweep all words to catch decode aliasing.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      memRead = 1'b1; memWrite = 1'b0; address = 32'(i * 4);
      #1 check("sweep", ReadData, model[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
